ot_drain_arb: RTL and testbench
===============================

# ot_drain_arb

Round-robin drain controller for the quantization output stage. It sequences N_CH output FIFO instances (64-bit, show-ahead, `empty_n`/`read`/`data_out`) onto one registered valid/ready output bus toward the DRAM writer. It grants channels in bounded bursts and counts beats against a per-tile total. It signals completion once the last beat has been accepted downstream.

## Interface
- `N_CH`, 4: number of FIFO channels drained (2..8).
- `DATA_BITS`, 64: FIFO/output word width.
- `BURST`, 4: max consecutive beats taken from one channel per grant (1..16).
- `CNT_BITS`, 16: width of tile beat counter.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `cfg_total_beats`; ignored unless IDLE.
- `cfg_total_beats`  in  CNT_BITS  beats to move for this tile (sum over channels).
- `fifo_empty_n`  in  N_CH  per-channel FIFO non-empty.
- `fifo_data`  in  N_CH*DATA_BITS  per-channel head word; ch k at bits [k*DATA_BITS +: DATA_BITS].
- `fifo_read`  out  N_CH  one-hot pop; head consumed at this edge.
- `ot_valid`  out  1  output word valid.
- `ot_ready`  in  1  downstream accepts when `ot_valid & ot_ready`.
- `ot_data`  out  DATA_BITS  output word.
- `ot_ch`  out  log2(N_CH)  source channel of `ot_data`.
- `busy`  out  1  high in any state but IDLE.
- `done`  out  1  one-cycle pulse, tile complete.

## Operation
- States: IDLE, ARB, XFER, DONE. Reset: IDLE, `ptr`=N_CH-1, `remain`=0, all outputs 0.
- IDLE: on `start`, `remain`<=`cfg_total_beats`. If the value is 0 -> DONE, else -> ARB.
- ARB: search channels ptr+1, ptr+2, … (mod N_CH) and take the first with `fifo_empty_n`. On a hit: `sel`<=hit, `ptr`<=hit, `bcnt`<=0, -> XFER. With no hit, stay in ARB (no timeout).
- XFER load condition: `ld = fifo_empty_n[sel] & (~ot_valid | ot_ready) & remain!=0`.
- On `ld`:
  - `fifo_read[sel]`=1 (combinational, same cycle).
  - `ot_data`<=`fifo_data[sel]`, `ot_ch`<=`sel`, `ot_valid`<=1.
  - `remain`--, `bcnt`++.
- When `ot_valid & ot_ready & ~ld`: `ot_valid`<=0.
- XFER exits, in priority order:
  - `ld` with `remain`==1 -> DONE.
  - `ld` with `bcnt`==BURST-1 -> ARB.
  - `~fifo_empty_n[sel]` -> ARB (burst ends early, no read issued).
  - Otherwise stay in XFER.
- DONE: wait until `ot_valid`==0, or `ot_valid & ot_ready` occurs this cycle. Then `done`=1 for that one cycle and go to IDLE.
- `fifo_read` is never asserted outside XFER, never for a non-granted channel, and never when the FIFO reports empty.
- `remain` never underflows. FIFO data beyond the tile total stays in the FIFO.
- Reset mid-operation: return to the reset state immediately. Any in-flight `ot_data` is dropped. FIFOs are untouched.
- `start` while busy: ignored, no state change.

## Timing
- `start` at cycle t -> ARB at t+1 -> XFER at t+2 if a channel was non-empty at t+1.
- First `fifo_read` occurs at t+2. First `ot_valid` occurs at t+3.
- Sustained throughput is 1 beat/cycle within a burst while `ot_ready`=1.
- Each channel switch costs exactly one ARB bubble cycle.
- With `ot_ready` held high, `done` asserts 1 cycle after the last beat's handshake cycle.
- Backpressure: `ot_data`/`ot_ch` stay stable while `ot_valid & ~ot_ready`, and no read is issued during that time.

## Structure
- Shared package `ot_pkg`:
  - State enum {IDLE, ARB, XFER, DONE}.
  - `OT_DATA_BITS`=64.
  - Default `N_CH`, `BURST`, `CNT_BITS`.
  - Channel-index width function.
- Sub-module `ot_rr_pick`: combinational rotate-priority encoder. Inputs `req[N_CH]` and `ptr`; outputs `hit` and `idx`. Reused by the other output-side arbiters.

## Test plan
- Single channel: `cfg_total_beats`=5, only ch2 has 5 words, `ot_ready`=1.
  - ch2 popped at t+2, t+3, t+4, t+5 (burst of 4).
  - ARB bubble, then one more pop. Output order is preserved, `ot_ch`=2.
  - `done` one cycle after the 5th handshake.
- Fairness: 4 channels each hold 8 words, total=32, BURST=4.
  - Grant order is 0,1,2,3,0,1,2,3, each grant 4 beats.
  - Exactly 32 reads, `done` once.
- Backpressure: hold `ot_ready`=0 for 3 cycles mid-burst.
  - `ot_data` is stable, no `fifo_read` during the stall.
  - No beat is lost or duplicated.
- Early empty: ch1 holds 2 words, ch3 holds 6 words, total=8.
  - ch1 gives 2 beats, then re-arbitration.
  - ch3 gives 4 beats, then ch3 again (only requester) gives 2 beats.
- Zero total: `start` with `cfg_total_beats`=0 -> `done` at t+2 with no reads. `start` pulsed while busy -> no effect.
- Reset mid-XFER: assert `reset` with `ot_valid`=1.
  - Next cycle: IDLE, `ot_valid`=0, `busy`=0.
  - A following `start` grants ch0 first.

Source files
------------

// File: rtl/ot_pkg.sv
// Shared types and defaults for the quantization output-stage drain logic.
package ot_pkg;

  typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} ot_state_e;

  localparam int OT_DATA_BITS = 64;
  localparam int OT_N_CH      = 4;
  localparam int OT_BURST     = 4;
  localparam int OT_CNT_BITS  = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ot_rr_pick.sv
// Rotate-priority encoder: first asserted req after ptr, wrapping mod N_CH.
module ot_rr_pick
  import ot_pkg::*;
#(
  parameter int N_CH = OT_N_CH,
  parameter int IW   = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            hit,
  output logic [IW-1:0]   idx
);

  // Scan farthest-to-nearest so the nearest requester after ptr wins last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_CH; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N_CH]) begin
        hit = 1'b1;
        idx = IW'((int'(ptr) + i) % N_CH);
      end
    end
  end

endmodule

// File: rtl/ot_drain_arb.sv
// Round-robin drain of N_CH show-ahead FIFOs onto one registered valid/ready
// bus, in bounded bursts, counting beats against a per-tile total.
module ot_drain_arb
  import ot_pkg::*;
#(
  parameter int N_CH      = OT_N_CH,
  parameter int DATA_BITS = OT_DATA_BITS,
  parameter int BURST     = OT_BURST,
  parameter int CNT_BITS  = OT_CNT_BITS,
  parameter int IW        = ch_w(N_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_BITS-1:0]       cfg_total_beats,
  input  logic [N_CH-1:0]           fifo_empty_n,
  input  logic [N_CH*DATA_BITS-1:0] fifo_data,
  output logic [N_CH-1:0]           fifo_read,
  output logic                      ot_valid,
  input  logic                      ot_ready,
  output logic [DATA_BITS-1:0]      ot_data,
  output logic [IW-1:0]             ot_ch,
  output logic                      busy,
  output logic                      done
);

  localparam int BW = $clog2(BURST + 1);

  ot_state_e              state, nstate;
  logic [IW-1:0]          ptr, sel, pick;
  logic [BW-1:0]          bcnt;
  logic [CNT_BITS-1:0]    remain;
  logic                   hit, sel_ne, ld, out_free;
  logic [DATA_BITS-1:0]   word;

  ot_rr_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .req (fifo_empty_n),
    .ptr (ptr),
    .hit (hit),
    .idx (pick)
  );

  assign sel_ne   = fifo_empty_n[sel];
  assign word     = fifo_data[int'(sel)*DATA_BITS +: DATA_BITS];
  // Output register can take a new word when empty or being drained now.
  assign out_free = ~ot_valid | ot_ready;
  assign ld       = (state == XFER) & sel_ne & out_free & (remain != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Next-state: burst limit and tile end take priority over early empty.
  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (start) nstate = (cfg_total_beats == '0) ? DONE : ARB;
      ARB:  if (hit) nstate = XFER;
      XFER: begin
        if (ld && remain == CNT_BITS'(1))      nstate = DONE;
        else if (ld && bcnt == BW'(BURST - 1)) nstate = ARB;
        else if (!sel_ne)                      nstate = ARB;
      end
      DONE: if (out_free) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs: pop strobe is same-cycle with the load; held off during reset
  // so the FIFOs never lose a word to a dropped transfer.
  always_comb begin
    busy      = (state != IDLE);
    fifo_read = '0;
    if (ld && !reset) fifo_read[sel] = 1'b1;
  end

  // Datapath: grant pointer, beat counters and the registered output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= IW'(N_CH - 1);
      sel      <= '0;
      bcnt     <= '0;
      remain   <= '0;
      ot_valid <= 1'b0;
      ot_data  <= '0;
      ot_ch    <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE) && out_free;
      if (state == IDLE && start) remain <= cfg_total_beats;
      if (state == ARB && hit) begin
        sel  <= pick;
        ptr  <= pick;
        bcnt <= '0;
      end
      if (ld) begin
        ot_data  <= word;
        ot_ch    <= sel;
        ot_valid <= 1'b1;
        remain   <= remain - CNT_BITS'(1);
        bcnt     <= bcnt + BW'(1);
      end else if (ot_ready) begin
        ot_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ot_drain_arb.sv
// Bench for ot_drain_arb: FIFO model, scoreboard of expected beats, vector
// table of tile scenarios plus hand-written timing/stall/reset sequences.
module tb_ot_drain_arb;

  logic         clk = 1'b0;
  logic         reset, start, ot_ready;
  logic [15:0]  cfg_total_beats;
  logic [3:0]   fifo_empty_n, fifo_read;
  logic [255:0] fifo_data;
  logic         ot_valid, busy, done;
  logic [63:0]  ot_data;
  logic [1:0]   ot_ch;

  ot_drain_arb dut (
    .clk(clk), .reset(reset), .start(start), .cfg_total_beats(cfg_total_beats),
    .fifo_empty_n(fifo_empty_n), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .ot_valid(ot_valid), .ot_ready(ot_ready), .ot_data(ot_data), .ot_ch(ot_ch),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic [3:0][7:0] cnt;    // words preloaded per channel
    int              total;  // cfg_total_beats
    logic [127:0]    seq;    // expected source channel of beat b at nibble b
    bit              rnd;    // random ot_ready
  } vec_t;

  int          n_asrt = 0, n_fail = 0;
  int          cnum = 0, rd_cnt, done_cnt, done_cyc, first_rd_ch, n_stall;
  int          rd_cyc[$], hs_cyc[$];
  exp_t        sb[$];
  logic [63:0] fq[4][$];
  logic [3:0]  pend;
  logic        prev_stall;
  logic [63:0] prev_data;
  logic [1:0]  prev_ch;
  vec_t        vecs[7];

  function automatic logic [63:0] mkw(input int ch, input int i, input int tag);
    return {8'hA5, 8'(ch), 16'(tag), 16'h5A5A, 16'(i)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      fifo_empty_n[k]       = (fq[k].size() != 0);
      fifo_data[k*64 +: 64] = (fq[k].size() != 0) ? fq[k][0] : 64'hDEAD_BEEF_DEAD_BEEF;
    end
  endtask

  task automatic clr_stats();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; first_rd_ch = -1; n_stall = 0;
    rd_cyc.delete(); hs_cyc.delete(); prev_stall = 1'b0;
  endtask

  // One clock: monitor at negedge, then FIFO pops just after the rising edge.
  task automatic tick();
    int rc;
    @(negedge clk);
    pend = 4'b0;
    if (!reset) begin
      if (fifo_read != 4'b0) begin
        chk("rd_onehot", $onehot(fifo_read), 1);
        chk("rd_nonempty", |(fifo_read & ~fifo_empty_n), 0);
        chk("rd_busy", busy, 1);
        chk("rd_stall", ot_valid & ~ot_ready, 0);
        rc = 0;
        for (int k = 0; k < 4; k++) if (fifo_read[k]) rc = k;
        if (first_rd_ch < 0) first_rd_ch = rc;
        rd_cnt++;
        rd_cyc.push_back(cnum);
        pend = fifo_read;
      end
      if (prev_stall) begin
        n_stall++;
        chk("stall_valid", ot_valid, 1);
        chk("stall_data", ot_data, prev_data);
        chk("stall_ch", ot_ch, prev_ch);
      end
      if (ot_valid && ot_ready) begin
        exp_t e;
        hs_cyc.push_back(cnum);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("beat_data", ot_data, e.data);
          chk("beat_ch", ot_ch, e.ch);
        end
      end
      if (done) begin done_cnt++; done_cyc = cnum; end
      prev_stall = ot_valid & ~ot_ready;
      prev_data  = ot_data;
      prev_ch    = ot_ch;
    end
    @(posedge clk);
    cnum++;
    #1;
    for (int k = 0; k < 4; k++) if (pend[k] && fq[k].size() != 0) void'(fq[k].pop_front());
    refresh();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; ot_ready = 1'b0;
    tick();
    reset = 1'b0;
    sb.delete();
    for (int k = 0; k < 4; k++) fq[k].delete();
    refresh();
    clr_stats();
  endtask

  task automatic load(input int ch, input int n, input int tag);
    for (int i = 0; i < n; i++) fq[ch].push_back(mkw(ch, i, tag));
    refresh();
  endtask

  task automatic push_exp(input logic [127:0] seq, input int total, input int tag);
    int idx[4];
    int c;
    idx = '{default: 0};
    for (int b = 0; b < total; b++) begin
      c = int'(seq[b*4 +: 4]);
      sb.push_back('{ch: 2'(c), data: mkw(c, idx[c], tag)});
      idx[c]++;
    end
  endtask

  task automatic wait_done(input int maxc, input bit rnd);
    for (int i = 0; i < maxc && done_cnt == 0; i++) begin
      ot_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
    end
    chk("done_seen", done_cnt != 0, 1);
    ot_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    int used[4];
    int c;
    do_reset();
    for (int k = 0; k < 4; k++) load(k, int'(v.cnt[k]), tag);
    push_exp(v.seq, v.total, tag);
    used = '{default: 0};
    for (int b = 0; b < v.total; b++) begin
      c = int'(v.seq[b*4 +: 4]);
      used[c]++;
    end
    cfg_total_beats = 16'(v.total); start = 1'b1; ot_ready = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000, v.rnd);
    chk("vec_done_once", done_cnt, 1);
    chk("vec_reads", rd_cnt, v.total);
    chk("vec_sb_left", sb.size(), 0);
    chk("vec_idle", busy, 0);
    for (int k = 0; k < 4; k++) chk("vec_residual", fq[k].size(), int'(v.cnt[k]) - used[k]);
  endtask

  initial begin
    int t0;
    int exp_rd[5];
    vecs[0] = '{cnt: {8'd0, 8'd5, 8'd0, 8'd0}, total: 5,  seq: 128'h22222,    rnd: 1'b0};
    vecs[1] = '{cnt: {8'd8, 8'd8, 8'd8, 8'd8}, total: 32,
                seq: 128'h33332222111100003333222211110000, rnd: 1'b0};
    vecs[2] = '{cnt: {8'd6, 8'd0, 8'd2, 8'd0}, total: 8,  seq: 128'h33333311, rnd: 1'b0};
    vecs[3] = '{cnt: {8'd0, 8'd0, 8'd3, 8'd3}, total: 4,  seq: 128'h1000,     rnd: 1'b0};
    vecs[4] = '{cnt: {8'd0, 8'd1, 8'd0, 8'd1}, total: 2,  seq: 128'h20,       rnd: 1'b1};
    vecs[5] = '{cnt: {8'd5, 8'd0, 8'd0, 8'd5}, total: 10, seq: 128'h3033330000, rnd: 1'b1};
    vecs[6] = vecs[1];
    vecs[6].rnd = 1'b1;

    reset = 1'b1; start = 1'b0; ot_ready = 1'b0; cfg_total_beats = '0;
    refresh();
    clr_stats();
    tick(); tick();
    chk("rst_valid", ot_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", fifo_read, 0);
    chk("rst_data", ot_data, 0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) run_vec(vecs[v], v + 1);

    // Single channel cycle timing: pops t+2..t+5, bubble, pop t+7.
    do_reset();
    load(2, 5, 100);
    push_exp(128'h22222, 5, 100);
    ot_ready = 1'b1; cfg_total_beats = 16'd5; start = 1'b1; t0 = cnum;
    tick();
    start = 1'b0;
    wait_done(100, 1'b0);
    exp_rd = '{2, 3, 4, 5, 7};
    for (int i = 0; i < 5; i++)
      chk("tm_read_cyc", (rd_cyc.size() > i) ? rd_cyc[i] - t0 : -1, exp_rd[i]);
    chk("tm_first_valid", (hs_cyc.size() > 0) ? hs_cyc[0] - t0 : -1, 3);
    chk("tm_done_lat", (hs_cyc.size() == 5) ? done_cyc - hs_cyc[4] : -1, 1);

    // Zero total, then start pulses while busy.
    do_reset();
    cfg_total_beats = 16'd0; start = 1'b1; t0 = cnum; ot_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("zero_done_once", done_cnt, 1);
    chk("zero_done_cyc", done_cyc - t0, 2);
    chk("zero_reads", rd_cnt, 0);
    clr_stats();
    load(0, 3, 200);
    load(1, 5, 201);
    push_exp(128'h0, 3, 200);
    cfg_total_beats = 16'd3; start = 1'b1;
    tick();
    chk("busy_arb", busy, 1);
    cfg_total_beats = 16'd10;
    tick(); tick();
    start = 1'b0;
    wait_done(100, 1'b0);
    chk("bs_reads", rd_cnt, 3);
    chk("bs_done_once", done_cnt, 1);
    chk("bs_ch1_untouched", fq[1].size(), 5);
    chk("bs_sb_left", sb.size(), 0);

    // Backpressure for 3 cycles mid-burst.
    do_reset();
    load(0, 6, 300);
    push_exp(128'h0, 6, 300);
    cfg_total_beats = 16'd6; start = 1'b1; ot_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && rd_cnt < 2; i++) tick();
    chk("bp_reach", rd_cnt >= 2, 1);
    ot_ready = 1'b0;
    repeat (3) tick();
    ot_ready = 1'b1;
    wait_done(100, 1'b0);
    chk("bp_stalls", n_stall >= 3, 1);
    chk("bp_reads", rd_cnt, 6);
    chk("bp_sb_left", sb.size(), 0);

    // Reset while a word is in flight; next tile starts from ch0.
    do_reset();
    load(1, 8, 400);
    load(2, 8, 401);
    cfg_total_beats = 16'd16; start = 1'b1; ot_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !ot_valid; i++) tick();
    chk("rm_inflight", ot_valid, 1);
    reset = 1'b1;
    tick();
    chk("rm_valid_clr", ot_valid, 0);
    chk("rm_busy_clr", busy, 0);
    reset = 1'b0;
    sb.delete();
    clr_stats();
    load(0, 2, 402);
    push_exp(128'h0, 2, 402);
    cfg_total_beats = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, 1'b0);
    chk("rm_first_ch0", first_rd_ch, 0);
    chk("rm_reads", rd_cnt, 2);
    chk("rm_sb_left", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
